// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status flags of imem_loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-2:0] num_words;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, num_words, in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_reset, busy, done, err
    );

    modport slave (
        input  start, num_words, in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Loads big-endian 32-bit words from a byte stream into instruction memory, holding the CPU in reset until done.
// Optional trailing checksum byte check enabled by macro IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int unsigned NW_W = ADDR_W - 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [NW_W-1:0]   nw_q, nw_d;
    logic [NW_W-1:0]   idx_q, idx_d;
    logic [NW_W-1:0]   idx_next;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            nw_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            nw_q        <= nw_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            im_we_q     <= im_we_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Next state and datapath; outputs are decoded from the next state so they register alongside it
    always_comb begin
        state_d  = state_q;
        nw_d     = nw_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        addr_d   = addr_q;
        err_d    = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        accept   = bus.in_valid & in_ready_q;
        idx_next = idx_q + NW_W'(1);

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    nw_d  = bus.num_words;
                    idx_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d = '0;
                    state_d = (bus.num_words != '0) ? RECV : CHK;
`else
                    state_d = (bus.num_words != '0) ? RECV : DONE;
`endif
                end
            end
            RECV: begin
                if (accept) begin
                    word_d = {word_q[23:0], bus.in_data};
                    cnt_d  = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + bus.in_data;
`endif
                    if (cnt_q == 2'd3) begin
                        // Word address wraps by truncation to the memory width
                        addr_d  = ADDR_W'({idx_q, 2'b00});
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = (idx_next == nw_q) ? CHK : RECV;
`else
                state_d = (idx_next == nw_q) ? DONE : RECV;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    err_d   = (8'(sum_q + bus.in_data) != 8'd0);
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready_d = (state_d == RECV) || (state_d == CHK);
        busy_d     = (state_d == RECV) || (state_d == WRITE) || (state_d == CHK);
`else
        in_ready_d = (state_d == RECV);
        busy_d     = (state_d == RECV) || (state_d == WRITE);
`endif
        im_we_d     = (state_d == WRITE);
        done_d      = (state_d == DONE);
        // A failed checksum keeps the CPU in reset even though the load is done
        cpu_reset_d = !((state_d == DONE) && !err_d);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.im_we     = im_we_q;
    assign bus.im_addr   = addr_q;
    assign bus.im_wdata  = word_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
